// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode constants, immediate extension modes
// and the decoded-immediate record produced by imm_decode.
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    typedef enum logic [2:0] {
        EXT_NONE   = 3'd0,
        EXT_ZERO   = 3'd1,
        EXT_SIGN   = 3'd2,
        EXT_HIGH   = 3'd3,
        EXT_BRANCH = 3'd4
    } ext_mode_t;

    typedef struct packed {
        logic [31:0] imm;
        ext_mode_t   mode;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode-driven immediate extender: selects the extension mode
// and builds the 32-bit operand from the 16-bit immediate field.
module imm_decode
    import mips_pkg::*;
(
    input  logic [5:0]  opcode_i,
    input  logic [15:0] imm_i,
    output dec_t        dec_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        dec_o = '{imm: 32'h0, mode: EXT_NONE, illegal: 1'b0};
        unique case (opcode_i)
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec_o.mode = EXT_ZERO;
                dec_o.imm  = {16'h0, imm_i};
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: begin
                dec_o.mode = EXT_SIGN;
                dec_o.imm  = {{16{imm_i[15]}}, imm_i};
            end
            OP_LUI: begin
                dec_o.mode = EXT_HIGH;
                dec_o.imm  = {imm_i, 16'h0};
            end
            OP_BEQ, OP_BNE: begin
                dec_o.mode = EXT_BRANCH;
                dec_o.imm  = {{14{imm_i[15]}}, imm_i, 2'b00};
            end
            OP_SPECIAL, OP_J, OP_JAL: ;
            default: dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_ext_ctrl.sv
// Decode-stage immediate controller: decodes the incoming instruction and
// holds results in a 2-entry skid buffer so in_ready never depends on out_ready.
module imm_ext_ctrl
    import mips_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_imm,
    output logic [2:0]       out_mode,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    typedef struct packed {
        dec_t             dec;
        logic [TAG_W-1:0] tag;
    } entry_t;

    state_t state_q;
    entry_t head_q;
    entry_t skid_q;
    entry_t new_entry;
    dec_t   dec;
    logic   accept;
    logic   pop;
    logic   unused_instr_bits;

    imm_decode u_decode (
        .opcode_i (in_instr[31:26]),
        .imm_i    (in_instr[15:0]),
        .dec_o    (dec)
    );

    // Register-select fields are decoded elsewhere in the stage.
    assign unused_instr_bits = ^in_instr[25:16];

    assign new_entry = '{dec: dec, tag: in_tag};
    assign in_ready  = (state_q != S_TWO);
    assign out_valid = (state_q != S_EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Head data is left untouched by flush; out_valid already masks it.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: data registers are reset too, because the outputs must read zero during reset.
        if (!rst_n) begin
            state_q <= S_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state_q <= S_EMPTY;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            unique case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        head_q  <= new_entry;
                        state_q <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && pop) begin
                        head_q <= new_entry;
                    end else if (accept) begin
                        skid_q  <= new_entry;
                        state_q <= S_TWO;
                    end else if (pop) begin
                        state_q <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (pop) begin
                        head_q  <= skid_q;
                        state_q <= S_ONE;
                    end
                end
                default: state_q <= S_EMPTY;
            endcase
        end
    end

    assign out_imm     = head_q.dec.imm;
    assign out_mode    = head_q.dec.mode;
    assign out_tag     = head_q.tag;
    assign out_illegal = head_q.dec.illegal;

endmodule
